// File: rtl/mips_defs_pkg.sv
// Shared MIPS pipeline definitions: exception codes, reset/handler addresses,
// and the D-stage register layout used by the IF/ID pipeline register.
package mips_defs;

  localparam logic [3:0]  EXC_NONE   = 4'd0;
  localparam logic [3:0]  EXC_ADEL   = 4'd4;
  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [3:0]  exc;
    logic        bd;
    logic        valid;
  } d_stage_t;

  typedef enum logic [1:0] {
    LD_FLUSH,
    LD_HOLD,
    LD_BUBBLE,
    LD_NORMAL
  } d_load_e;

  // A bubble keeps the fetch address so EPC logic always sees a defined PC.
  function automatic d_stage_t d_bubble(input logic [31:0] pc, input logic [31:0] pc4);
    d_stage_t b;
    b.instr = NOP_INSTR;
    b.pc    = pc;
    b.pc4   = pc4;
    b.exc   = EXC_NONE;
    b.bd    = 1'b0;
    b.valid = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures the fetched instruction, PC, PC+4 and
// fetch exception; handles stall hold, flush, post-ERET bubble and BD tracking.
module if_id_reg
  import mips_defs::d_stage_t;
  import mips_defs::d_load_e;
  import mips_defs::LD_FLUSH;
  import mips_defs::LD_HOLD;
  import mips_defs::LD_BUBBLE;
  import mips_defs::LD_NORMAL;
  import mips_defs::d_bubble;
  import mips_defs::EXC_NONE;
  import mips_defs::NOP_INSTR;
#(
  parameter logic [31:0] RESET_PC = mips_defs::RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] F_instr,
  input  logic [31:0] F_pc,
  input  logic [31:0] F_pc4,
  input  logic [3:0]  F_exc,
  input  logic        stall,
  input  logic        flush,
  input  logic        D_is_jump,
  input  logic        D_is_eret,
  output logic [31:0] D_instr,
  output logic [31:0] D_pc,
  output logic [31:0] D_pc4,
  output logic [3:0]  D_exc,
  output logic        D_bd,
  output logic        D_valid
);

  d_stage_t d_q, d_d;
  d_load_e  load_sel;

  // Priority below reset: flush > stall > eret bubble > normal load.
  always_comb begin
    load_sel = LD_NORMAL;
    if (flush)          load_sel = LD_FLUSH;
    else if (stall)     load_sel = LD_HOLD;
    else if (D_is_eret) load_sel = LD_BUBBLE;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    d_d = d_q;
    unique case (load_sel)
      LD_FLUSH,
      LD_BUBBLE: d_d = d_bubble(F_pc, F_pc4);
      LD_HOLD:   d_d = d_q;
      LD_NORMAL: begin
        d_d.instr = F_instr;
        d_d.pc    = F_pc;
        d_d.pc4   = F_pc4;
        d_d.exc   = F_exc;
        // The instruction entering D sits in a delay slot iff the one leaving is a branch/jump.
        d_d.bd    = D_is_jump;
        d_d.valid = 1'b1;
      end
      default:   d_d = d_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      d_q.instr <= NOP_INSTR;
      d_q.pc    <= RESET_PC;
      d_q.pc4   <= RESET_PC + 32'd4;
      d_q.exc   <= EXC_NONE;
      d_q.bd    <= 1'b0;
      d_q.valid <= 1'b0;
    end else begin
      d_q <= d_d;
    end
  end

  assign D_instr = d_q.instr;
  assign D_pc    = d_q.pc;
  assign D_pc4   = d_q.pc4;
  assign D_exc   = d_q.exc;
  assign D_bd    = d_q.bd;
  assign D_valid = d_q.valid;

endmodule
